// File: rtl/sha3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha3_pkg
// Description : Shared types and constants for the SHA-3 pad/absorb front end.
//               Provides the 5x5x64 state image type, the variant encoding,
//               the per-variant rate (in bytes), the padding bytes and the
//               FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sha3_pkg;

  // 5x5 lanes of 64 bits. Flattened, byte b of the block sits at bits [8*b +: 8].
  typedef logic [4:0][4:0][63:0] state_t;

  typedef enum logic [1:0] {
    V224 = 2'b00,
    V256 = 2'b01,
    V384 = 2'b10,
    V512 = 2'b11
  } variant_e;

  typedef enum logic [1:0] {
    FILL   = 2'b00,
    EMIT   = 2'b01,
    PADBLK = 2'b10
  } fsm_e;

  localparam logic [7:0] PAD_DOMAIN = 8'h06;
  localparam logic [7:0] PAD_END    = 8'h80;

  // Rate in bytes for each variant.
  function automatic logic [7:0] rate_bytes(input logic [1:0] mode);
    case (variant_e'(mode))
      V224:    return 8'd144;
      V256:    return 8'd136;
      V384:    return 8'd104;
      default: return 8'd72;
    endcase
  endfunction

endpackage : sha3_pkg
`default_nettype wire

// File: rtl/sha3_byte_writer.sv
`default_nettype none
// ============================================================================
// Module      : sha3_byte_writer
// Description : Combinational byte merge into a state image. When enabled,
//               byte_i is ORed into byte idx_i of state_i; otherwise the state
//               passes through unchanged. OR-merge lets the padding bytes
//               combine (0x06 | 0x80 = 0x86 when they land on the same byte).
// Ports       : state_i  in  state_t  incoming state image
//               idx_i    in  8        byte index (0..199)
//               byte_i   in  8        byte value to merge
//               en_i     in  1        merge enable
//               state_o  out state_t  updated state image
// Revision    : 1.0 - initial release
// ============================================================================
module sha3_byte_writer
  import sha3_pkg::*;
(
  input  state_t     state_i,
  input  logic [7:0] idx_i,
  input  logic [7:0] byte_i,
  input  logic       en_i,
  output state_t     state_o
);

  logic [1599:0] flat;
  logic [10:0]   bit_pos;

  always_comb begin
    flat    = state_i;
    bit_pos = {idx_i, 3'b000};
    if (en_i && (idx_i < 8'd200)) begin
      flat[bit_pos +: 8] = flat[bit_pos +: 8] | byte_i;
    end
    state_o = flat;
  end

endmodule : sha3_byte_writer
`default_nettype wire

// File: rtl/sha3_pad_absorb.sv
`default_nettype none
// ============================================================================
// Module      : sha3_pad_absorb
// Description : Collects AXI-Stream message words into one rate-sized block,
//               applies SHA-3 padding (0x06 ... 0x80) and presents each block
//               as a 5x5x64 state image with valid/ready/last. The variant is
//               latched on the first beat of each message.
// Ports       : ACLK, ARESETn          clock, async active-low reset
//               TVALID_i/TREADY        input beat handshake
//               TDATA_i                message bytes, first byte in [7:0]
//               TKEEP_i                byte enables, used on the last beat only
//               TLAST_i                final beat of message
//               TUSER_i                variant, sampled on first beat
//               blk_data               padded block (capacity lanes zero)
//               blk_valid/blk_ready    block handshake
//               blk_last               final block of message
//               blk_mode               latched variant for this message
// Revision    : 1.0 - initial release
// ============================================================================
module sha3_pad_absorb
  import sha3_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    TVALID_i,
  output logic                    TREADY,
  input  logic [DATA_WIDTH-1:0]   TDATA_i,
  input  logic [DATA_WIDTH/8-1:0] TKEEP_i,
  input  logic                    TLAST_i,
  input  logic [1:0]              TUSER_i,
  output state_t                  blk_data,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic                    blk_last,
  output logic [1:0]              blk_mode
);

  localparam int NB = DATA_WIDTH / 8;

  fsm_e        state_q, state_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [1:0]  mode_q, mode_d;
  logic        last_q, last_d;
  logic        pend_q, pend_d;     // extra all-padding block owed
  logic        in_msg_q, in_msg_d; // a message has started and not yet ended
  state_t      buf_q, buf_d;

  logic          fire;
  logic [1:0]    cur_mode;
  logic [7:0]    rate;
  logic [3:0]    keep_cnt;
  logic          keep_run;
  logic [7:0]    p_end;
  logic [NB-1:0] byte_en;
  logic          pad_en;
  logic [7:0]    pad_idx;
  state_t        data_chain [NB+1];
  state_t        pad_mid;
  state_t        pad_out;

  // Gating with ARESETn keeps TREADY low while reset is held.
  assign TREADY    = (state_q == FILL) && ARESETn;
  assign fire      = TVALID_i && TREADY;
  assign blk_data  = buf_q;
  assign blk_valid = (state_q == EMIT);
  assign blk_last  = last_q;
  assign blk_mode  = mode_q;

  // The variant comes from TUSER_i only on the opening beat of a message.
  assign cur_mode = ((state_q == FILL) && !in_msg_q) ? TUSER_i : mode_q;
  assign rate     = rate_bytes(cur_mode);

  // Trailing-ones count of TKEEP_i; anything above the first hole is dropped.
  always_comb begin
    keep_cnt = '0;
    keep_run = 1'b1;
    for (int i = 0; i < NB; i++) begin
      if (keep_run && TKEEP_i[i]) keep_cnt = keep_cnt + 4'd1;
      else                        keep_run = 1'b0;
    end
    for (int i = 0; i < NB; i++) begin
      byte_en[i] = fire && (!TLAST_i || (4'(i) < keep_cnt));
    end
  end

  assign p_end = ptr_q + {4'b0000, keep_cnt};

  assign data_chain[0] = buf_q;
  for (genvar gi = 0; gi < NB; gi++) begin : g_data_wr
    sha3_byte_writer u_wr (
      .state_i (data_chain[gi]),
      .idx_i   (ptr_q + 8'(gi)),
      .byte_i  (TDATA_i[8*gi +: 8]),
      .en_i    (byte_en[gi]),
      .state_o (data_chain[gi+1])
    );
  end

  sha3_byte_writer u_pad_dom (
    .state_i (data_chain[NB]),
    .idx_i   (pad_idx),
    .byte_i  (PAD_DOMAIN),
    .en_i    (pad_en),
    .state_o (pad_mid)
  );

  sha3_byte_writer u_pad_end (
    .state_i (pad_mid),
    .idx_i   (rate - 8'd1),
    .byte_i  (PAD_END),
    .en_i    (pad_en),
    .state_o (pad_out)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    mode_d   = mode_q;
    last_d   = last_q;
    pend_d   = pend_q;
    in_msg_d = in_msg_q;
    buf_d    = buf_q;
    pad_en   = 1'b0;
    pad_idx  = '0;

    case (state_q)
      FILL: begin
        if (fire) begin
          mode_d   = cur_mode;
          in_msg_d = 1'b1;
          if (!TLAST_i) begin
            ptr_d = ptr_q + 8'(NB);
            if (ptr_d == rate) begin
              state_d = EMIT;
              last_d  = 1'b0;
            end
          end else begin
            ptr_d    = p_end;
            in_msg_d = 1'b0;
            state_d  = EMIT;
            if (p_end < rate) begin
              pad_en  = 1'b1;
              pad_idx = p_end;
              last_d  = 1'b1;
            end else begin
              // Tail filled the block exactly: padding goes in a block of its own.
              last_d = 1'b0;
              pend_d = 1'b1;
            end
          end
          buf_d = pad_out;
        end
      end

      EMIT: begin
        if (blk_ready) begin
          buf_d   = '0;
          ptr_d   = '0;
          state_d = pend_q ? PADBLK : FILL;
        end
      end

      PADBLK: begin
        // buf_q was cleared on the preceding handshake.
        pad_en  = 1'b1;
        pad_idx = 8'd0;
        buf_d   = pad_out;
        last_d  = 1'b1;
        pend_d  = 1'b0;
        state_d = EMIT;
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= FILL;
      ptr_q    <= '0;
      mode_q   <= '0;
      last_q   <= 1'b0;
      pend_q   <= 1'b0;
      in_msg_q <= 1'b0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      mode_q   <= mode_d;
      last_q   <= last_d;
      pend_q   <= pend_d;
      in_msg_q <= in_msg_d;
      buf_q    <= buf_d;
    end
  end

endmodule : sha3_pad_absorb
`default_nettype wire
